dmem_arbiter: RTL and testbench

//  Shares the data-memory/IO block (DMIO) between the single-cycle CPU datapath and a host/debug port.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 20 ++
 rtl/dmem_arbiter_age_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths, the
// ack-phase state type and the wait-counter width helper.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 13;
  localparam int DMEM_DATA_W = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACK  = 1'b1
  } arb_state_t;

  // Bits needed to count 0..max_wait, never less than one.
  function automatic int wait_cnt_w(input int max_wait);
    if (max_wait < 1) return 1;
    return (max_wait + 1 > 2) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Host/debug access port of the data-memory arbiter.
// Handshake: the master raises req with wr/addr/wdata stable and holds them
// until ack. ack is a one-cycle pulse in the cycle after the grant, and rdata
// is valid with it. req seen during the ack cycle is ignored. A req still high
// after ack is treated as a new transaction, so at most one completes every
// two cycles.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) ();
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, wr, addr, wdata, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_arbiter_age_counter.sv
// Saturating age counter: it counts how many cycles a pending host request
// has been refused, and flags when it has reached the forcing limit.
module arb_age_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam int W = wait_cnt_w(MAX_WAIT);

  logic [W-1:0] cnt_q;

  assign sat = (cnt_q == W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU datapath and a host/debug port.
// CPU wins ties until the host has waited MAX_WAIT cycles. Optional
// statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  dmem_arbiter_if.slave     host,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stat_stalls,
  output logic [CNT_W-1:0]  stat_host_grants,
  output arb_state_t        dbg_state
);
  arb_state_t        state_q, state_d;
  logic              ack_phase;
  logic              host_elig;
  logic              gnt_host;
  logic              gnt_cpu;
  logic              wait_sat;
  logic [DATA_W-1:0] rdata_q;

  assign ack_phase = (state_q == ARB_ACK);
  assign host_elig = host.req & ~ack_phase;
  assign gnt_host  = host_elig & (~cpu_req | wait_sat);
  assign gnt_cpu   = cpu_req & ~gnt_host;
  assign cpu_stall = cpu_req & gnt_host;
  assign cpu_rdata = mem_rdata;
  assign host.ack   = ack_phase;
  assign host.rdata = rdata_q;
  assign dbg_state  = state_q;

  arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~host_elig | gnt_host),
    .inc   (host_elig & ~gnt_host),
    .sat   (wait_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_host) rdata_q <= mem_rdata;
    end
  end

  // The ack cycle follows every host grant; idle otherwise.
  always_comb begin
    state_d   = ARB_IDLE;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr    = 1'b0;
    if (gnt_host) begin
      state_d   = ARB_ACK;
      mem_addr  = host.addr;
      mem_wdata = host.wdata;
      mem_wr    = host.wr;
    end else if (gnt_cpu) begin
      mem_wr = cpu_wr;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] stalls_q;
  logic [CNT_W-1:0] grants_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_q <= '0;
      grants_q <= '0;
    end else begin
      if (cpu_stall && (stalls_q != '1)) stalls_q <= stalls_q + CNT_W'(1);
      if (gnt_host  && (grants_q != '1)) grants_q <= grants_q + CNT_W'(1);
    end
  end

  assign stat_stalls      = stalls_q;
  assign stat_host_grants = grants_q;
`else
  assign stat_stalls      = '0;
  assign stat_host_grants = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus random traffic
// checked every cycle against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW   = 13;
  localparam int DW   = 64;
  localparam int MAXW = 4;
  localparam int CW   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (MAX_WAIT=4) ----------------
  logic          cpu_req, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wr;
  logic [CW-1:0] stat_stalls, stat_host_grants;
  arb_state_t    dbg_state;
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) h ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host(h),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .stat_stalls(stat_stalls), .stat_host_grants(stat_host_grants),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (MAX_WAIT=0, host priority) ----------------
  logic          c0_req;
  logic [DW-1:0] c0_rdata, m0_wdata;
  logic [DW-1:0] m0_rdata = '0;
  logic          c0_stall, m0_wr;
  logic [AW-1:0] m0_addr;
  logic [CW-1:0] s0_stalls, s0_grants;
  arb_state_t    dbg_state0;
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) h0 ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(c0_req), .cpu_wr(1'b0), .cpu_addr(13'h005), .cpu_wdata(64'h0),
    .cpu_rdata(c0_rdata), .cpu_stall(c0_stall),
    .host(h0),
    .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_wr(m0_wr), .mem_rdata(m0_rdata),
    .stat_stalls(s0_stalls), .stat_host_grants(s0_grants),
    .dbg_state(dbg_state0)
  );

  // ---------------- DMIO memory (combinational read, clocked write) ----------------
  logic [DW-1:0] dmem    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_wr) dmem[mem_addr] <= mem_wdata;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: cycles waited, ack pending, last captured host data, stats.
  int          m_wait;
  bit          m_ack;
  logic [DW-1:0] m_rdata;
  int          m_stalls, m_grants;

  always @(negedge clk) begin : model
    bit            elig, gh, gc, e_wr, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (!rst_n) begin
      m_wait = 0; m_ack = 0; m_rdata = '0; m_stalls = 0; m_grants = 0;
      exp_q.delete();
    end
    elig    = h.req && !m_ack;
    gh      = elig && (!cpu_req || (m_wait == MAXW));
    gc      = cpu_req && !gh;
    e_addr  = gh ? h.addr  : cpu_addr;
    e_wd    = gh ? h.wdata : cpu_wdata;
    e_wr    = gh ? h.wr    : (gc && cpu_wr);
    e_stall = cpu_req && gh;
    chk("mem_addr",   mem_addr,  e_addr);
    chk("mem_wdata",  mem_wdata, e_wd);
    chk("mem_wr",     mem_wr,    e_wr);
    chk("cpu_stall",  cpu_stall, e_stall);
    chk("cpu_rdata",  cpu_rdata, ref_mem[e_addr]);
    chk("host_ack",   h.ack,     m_ack);
    chk("host_rdata", h.rdata,   m_rdata);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stalls", stat_stalls,      m_stalls);
    chk("stat_grants", stat_host_grants, m_grants);
`else
    chk("stat_stalls", stat_stalls,      0);
    chk("stat_grants", stat_host_grants, 0);
`endif
    if (m_ack) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_scoreboard: got ack want no ack (queue empty)");
      end else begin
        chk("host_rdata_q", h.rdata, exp_q.pop_front());
      end
    end
    if (rst_n) begin
      if (gh) begin
        m_rdata = ref_mem[h.addr];
        exp_q.push_back(m_rdata);
        m_grants++;
      end
      if (e_stall) m_stalls++;
      if (!elig || gh) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
      m_ack = gh;
    end
    if (e_wr) ref_mem[e_addr] = e_wd;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_host(input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    h.req = req; h.wr = wr; h.addr = a; h.wdata = d;
  endtask

  task automatic do_reset();
    drive_cpu(0, 0, '0, '0);
    drive_host(0, 0, '0, '0);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b0;
    drive_cpu(0, 0, '0, '0);
    drive_host(0, 0, '0, '0);
    c0_req = 0;
    h0.req = 0; h0.wr = 0; h0.addr = 13'h003; h0.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_host_ack",   h.ack,     0);
    chk("rst_host_rdata", h.rdata,   0);
    chk("rst_cpu_stall",  cpu_stall, 0);
    chk("rst_stat_stalls", stat_stalls, 0);

    // CPU-only store then load of the same word
    step(); drive_cpu(1, 1, 13'h010, 64'hDEAD); #1;
    chk("cpu_st_mem_wr", mem_wr, 1);
    chk("cpu_st_stall",  cpu_stall, 0);
    chk("cpu_st_addr",   mem_addr, 13'h010);
    step(); drive_cpu(1, 0, 13'h010, 64'h0); #1;
    chk("cpu_ld_rdata", cpu_rdata, 64'hDEAD);
    chk("cpu_ld_mem_wr", mem_wr, 0);

    // Host-only read of 0x020 holding 0x55, req held through the ack cycle
    step(); drive_cpu(1, 1, 13'h020, 64'h55);
    step(); drive_cpu(0, 0, 13'h007, 64'h0); drive_host(1, 0, 13'h020, 64'h0); #1;
    chk("host_rd_addr", mem_addr, 13'h020);
    step(); #1;
    chk("host_rd_ack",   h.ack,   1);
    chk("host_rd_data",  h.rdata, 64'h55);
    chk("host_ack_nogrant", mem_addr, 13'h007);
    step(); drive_host(0, 0, 13'h0, 64'h0); #1;
    chk("host_ack_pulse", h.ack, 0);

    // Contention from a clean reset; the host-priority instance runs alongside
    do_reset();
    step();
    drive_cpu(1, 0, 13'h030, 64'h0); drive_host(1, 0, 13'h040, 64'h0);
    c0_req = 1; h0.req = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("cont_stall", cpu_stall, (c == 4));
      chk("cont_addr",  mem_addr,  (c == 4) ? 13'h040 : 13'h030);
      if (c == 0) chk("mw0_stall", c0_stall, 1);
      if (c == 1) begin
        chk("mw0_stall_ack", c0_stall, 0);
        chk("mw0_ack",       h0.ack,   1);
        c0_req = 0; h0.req = 0;
      end
      @(posedge clk); #1;
    end
    #1;
    chk("cont_ack",       h.ack,     1);
    chk("cont_ack_stall", cpu_stall, 0);
    drive_host(0, 0, 13'h0, 64'h0); drive_cpu(0, 0, 13'h0, 64'h0);
    step(); #1;
`ifdef DMEM_ARB_STATS_EN
    chk("cont_stat_stalls", stat_stalls,      1);
    chk("cont_stat_grants", stat_host_grants, 1);
`else
    chk("cont_stat_stalls", stat_stalls,      0);
    chk("cont_stat_grants", stat_host_grants, 0);
`endif

    // Reset asserted during the ack cycle discards the ack and data
    drive_host(1, 0, 13'h020, 64'h0);
    step(); #1;
    chk("rstack_pre_ack", h.ack, 1);
    rst_n = 1'b0;
    drive_host(0, 0, 13'h0, 64'h0);
    #1;
    chk("rstack_ack",   h.ack,   0);
    chk("rstack_rdata", h.rdata, 0);
    step(); step();
    rst_n = 1'b1;
    drive_cpu(1, 0, 13'h011, 64'h0); drive_host(1, 1, 13'h012, 64'h77);
    #1;
    chk("rstack_wait_clear", cpu_stall, 0);

    // Random traffic; the host honours the req/ack handshake
    for (int n = 0; n < 3000; n++) begin
      step();
      drive_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 1),
                AW'($urandom_range(0, 31)), {$urandom, $urandom});
      if (h.req && h.ack) begin
        if ($urandom_range(0, 1))
          drive_host(1, $urandom_range(0, 1), AW'($urandom_range(0, 31)), {$urandom, $urandom});
        else
          drive_host(0, 0, '0, '0);
      end else if (!h.req && $urandom_range(0, 9) < 3) begin
        drive_host(1, $urandom_range(0, 1), AW'($urandom_range(0, 31)), {$urandom, $urandom});
      end
    end
    step();
    drive_cpu(0, 0, '0, '0);
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
